pixel_stream_src: RTL and testbench

- Frame source for the streaming convolution layer.
- On a start pulse, reads one IMG_H x IMG_W signed image from a synchronous-read pixel RAM (1-cycle read latency).
- Emits the image in raster order on the valid_pixel/pixel_out stream, optionally wrapped in a zero border of PAD pixels.
- Drives the pixel input side of the conv layer; the stream interface has no backpressure, so flow control is an upstream stall that suppresses issue.

---
 rtl/pixel_stream_src_if.sv | 23 ++
 rtl/pixel_stream_src.sv | 138 +++++++++++++
 tb/tb_pixel_stream_src.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_src_if.sv
// Bus bundle for the pixel frame source: RAM read port plus the outgoing pixel stream.
// The master side is the frame source; the slave side is the RAM and the pixel consumer.
interface pixel_stream_src_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic                     mem_rd_en;
  logic [ADDR_W-1:0]        mem_addr;
  logic signed [DATA_W-1:0] mem_rdata;
  logic                     valid_pixel;
  logic signed [DATA_W-1:0] pixel_out;
  logic                     frame_last;

  modport master (
    output mem_rd_en, mem_addr, valid_pixel, pixel_out, frame_last,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd_en, mem_addr, valid_pixel, pixel_out, frame_last,
    output mem_rdata
  );
endinterface

// File: rtl/pixel_stream_src.sv
// Frame source: scans an optionally zero-padded image out of a 1-cycle-latency pixel RAM
// and streams it in raster order, two cycles behind each issued position.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_RUN   | issuing one scan position per unstalled cycle
// S_DRAIN | letting the two pipeline stages empty
// S_DONE  | one-cycle done pulse
module pixel_stream_src #(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int DATA_W = 8,
  parameter int PAD    = 0,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stall,
  output logic              o_busy,
  output logic              o_done,
  pixel_stream_src_if.master bus
);

  localparam logic [7:0] L_OW1 = 8'(IMG_W + 2*PAD - 1);
  localparam logic [7:0] L_OH1 = 8'(IMG_H + 2*PAD - 1);
  localparam logic [8:0] L_PAD = 9'(PAD);
  localparam logic [7:0] L_W   = 8'(IMG_W);
  localparam logic [7:0] L_H   = 8'(IMG_H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_next;
  logic [7:0] r_row;
  logic [7:0] r_col;
  logic       r_drain;

  logic r_s1_valid;
  logic r_s1_pad;
  logic r_s1_last;
  logic r_valid;
  logic r_last;
  logic signed [DATA_W-1:0] r_pix;

  logic [8:0]        w_row_off;
  logic [8:0]        w_col_off;
  logic              w_pad;
  logic              w_last_pos;
  logic              w_issue;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic              w_busy;
  logic              w_done;

  // Offsets into the stored image; bit 8 set means the position is in the leading border.
  assign w_row_off  = {1'b0, r_row} - L_PAD;
  assign w_col_off  = {1'b0, r_col} - L_PAD;
  assign w_pad      = w_row_off[8] | w_col_off[8] |
                      (w_row_off[7:0] >= L_H) | (w_col_off[7:0] >= L_W);
  assign w_last_pos = (r_row == L_OH1) && (r_col == L_OW1);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   if (w_issue && w_last_pos) w_next = S_DRAIN;
      S_DRAIN: if (r_drain == 1'b0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = (r_state != S_IDLE);
    w_done  = (r_state == S_DONE);
    w_issue = (r_state == S_RUN) && !i_stall;
    w_rd_en = w_issue && !w_pad;
    w_addr  = '0;
    if (w_rd_en)
      w_addr = ADDR_W'(w_row_off[7:0]) * ADDR_W'(IMG_W) + ADDR_W'(w_col_off[7:0]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row   <= '0;
      r_col   <= '0;
      r_drain <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_issue) begin
        if (r_col == L_OW1) begin
          r_col <= '0;
          r_row <= r_row + 8'd1;
        end else begin
          r_col <= r_col + 8'd1;
        end
      end
      if (w_issue && w_last_pos) r_drain <= 1'b1;
      else if (r_state == S_DRAIN) r_drain <= r_drain - 1'b1;
    end
  end

  // Stage 1 lines up with mem_rdata; pad positions never read RAM and are forced to zero here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_pad   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_pix      <= '0;
    end else begin
      r_s1_valid <= w_issue;
      r_s1_pad   <= w_pad;
      r_s1_last  <= w_issue && w_last_pos;
      r_valid    <= r_s1_valid;
      r_last     <= r_s1_valid && r_s1_last;
      r_pix      <= (r_s1_valid && !r_s1_pad) ? bus.mem_rdata : '0;
    end
  end

  assign bus.mem_rd_en   = w_rd_en;
  assign bus.mem_addr    = w_addr;
  assign bus.valid_pixel = r_valid;
  assign bus.pixel_out   = r_pix;
  assign bus.frame_last  = r_last;
  assign o_busy          = w_busy;
  assign o_done          = w_done;

endmodule

// File: tb/tb_pixel_stream_src.sv
// Bench for pixel_stream_src: a PAD=0 and a PAD=1 instance, a raster-order frame model,
// and directed start/stall/reset sequences with hand-computed cycle expectations.
module tb_pixel_stream_src;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start0, start1, stall;
  logic busy0, done0, busy1, done1;

  pixel_stream_src_if #(.DATA_W(8), .ADDR_W(8)) if0 ();
  pixel_stream_src_if #(.DATA_W(8), .ADDR_W(8)) if1 ();

  pixel_stream_src #(.IMG_W(5), .IMG_H(5), .DATA_W(8), .PAD(0), .ADDR_W(8)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_stall(stall),
    .o_busy(busy0), .o_done(done0), .bus(if0));

  pixel_stream_src #(.IMG_W(5), .IMG_H(5), .DATA_W(8), .PAD(1), .ADDR_W(8)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_stall(stall),
    .o_busy(busy1), .o_done(done1), .bus(if1));

  // Pixel RAMs; a junk value appears on cycles without a read so pad zeroing is observable.
  logic signed [7:0] ram0 [0:255];
  logic signed [7:0] ram1 [0:255];
  always @(posedge clk) if0.mem_rdata <= if0.mem_rd_en ? ram0[if0.mem_addr] : 8'sh5A;
  always @(posedge clk) if1.mem_rdata <= if1.mem_rd_en ? ram1[if1.mem_addr] : 8'sh5A;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_now(input string nm, input int act);
    n_checks++;
    $display("FAIL %s: got %0d with nothing expected (cycle %0d)", nm, act, cyc);
  endtask

  // Frame model: every expected pixel and RAM address of an accepted frame, in raster order.
  logic signed [7:0] exp_pix[$];
  int                exp_addr[$];
  int  sel = 0, base = 0, cur_n = 25;
  bit  monitor_en = 1'b0;

  int first_v, last_c, done_c, busy_low, first_busy, nvalid, nrd, nzero, gaps;
  int tot_valid, tot_done;
  bit seen_busy;
  logic signed [7:0] first_pix, last_pix;

  logic mv, ml, mr, mb, md;
  logic signed [7:0] mp;
  logic [7:0] ma;
  logic signed [7:0] e;
  int rel_m;

  always @(negedge clk) begin
    if (monitor_en) begin
      mv = sel ? if1.valid_pixel : if0.valid_pixel;
      ml = sel ? if1.frame_last  : if0.frame_last;
      mp = sel ? if1.pixel_out   : if0.pixel_out;
      mr = sel ? if1.mem_rd_en   : if0.mem_rd_en;
      ma = sel ? if1.mem_addr    : if0.mem_addr;
      mb = sel ? busy1 : busy0;
      md = sel ? done1 : done0;
      rel_m = cyc - base;
      if (mb && first_busy < 0) first_busy = rel_m;
      if (mb) seen_busy = 1'b1;
      else if (seen_busy && busy_low < 0) busy_low = rel_m;
      if (md) begin done_c = rel_m; tot_done++; end
      if (mv) begin
        tot_valid++;
        if (exp_pix.size() == 0) fail_now("unexpected pixel", int'(mp));
        else begin
          e = exp_pix.pop_front();
          chk("pixel value", int'(mp), int'(e));
          chk("frame_last on pixel", int'(ml), int'(exp_pix.size() == 0));
        end
        if (nvalid == 0) begin first_v = rel_m; first_pix = mp; end
        nvalid++;
        last_pix = mp;
        if (mp == 0) nzero++;
        if (ml) last_c = rel_m;
      end else begin
        chk("idle pixel_out", int'(mp), 0);
        chk("idle frame_last", int'(ml), 0);
        if (nvalid > 0 && nvalid < cur_n) gaps++;
      end
      if (mr) begin
        nrd++;
        if (exp_addr.size() == 0) fail_now("unexpected mem_rd_en", int'(ma));
        else chk("mem_addr", int'(ma), exp_addr.pop_front());
      end else begin
        chk("idle mem_addr", int'(ma), 0);
      end
    end
  end

  bit start_m [0:127];
  bit stall_m [0:127];
  int rst_at;

  task automatic clear_seq();
    for (int i = 0; i < 128; i++) begin start_m[i] = 1'b0; stall_m[i] = 1'b0; end
    rst_at = -1;
  endtask

  task automatic accept_frame(input int d, input int rel);
    int p, ow, oh, idx;
    p  = d ? 1 : 0;
    ow = 5 + 2*p;
    oh = 5 + 2*p;
    cur_n = ow * oh;
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++) begin
        if (r < p || r >= p + 5 || c < p || c >= p + 5) exp_pix.push_back(8'sd0);
        else begin
          idx = (r - p) * 5 + (c - p);
          exp_pix.push_back(d ? ram1[idx] : ram0[idx]);
          exp_addr.push_back(idx);
        end
      end
    first_v = -1; last_c = -1; done_c = -1; busy_low = -1; first_busy = -1;
    nvalid = 0; nrd = 0; nzero = 0; gaps = 0; seen_busy = 1'b0;
    first_pix = 8'sd0; last_pix = 8'sd0;
    chk("frame accepted at", rel, rel);
  endtask

  task automatic run_seq(input int d, input int len);
    int model_end, nstall;
    bit pend_flush, st, rs;
    sel = d; base = cyc; monitor_en = 1'b1;
    model_end = -1; pend_flush = 1'b0;
    tot_valid = 0; tot_done = 0;
    for (int rel = 0; rel < len; rel++) begin
      if (pend_flush) begin
        exp_pix.delete(); exp_addr.delete();
        pend_flush = 1'b0; model_end = -1;
      end
      if (rst_at >= 0 && rel > rst_at && rel < rst_at + 5)
        chk("idle after reset", int'(d ? (if1.valid_pixel | busy1) : (if0.valid_pixel | busy0)), 0);
      st = start_m[rel]; rs = (rel == rst_at);
      rst = rs; stall = stall_m[rel];
      if (d != 0) start1 = st; else start0 = st;
      if (rs) pend_flush = 1'b1;
      else if (st && rel > model_end) begin
        nstall = 0;
        for (int k = rel + 1; k < 128; k++) if (stall_m[k]) nstall++;
        model_end = rel + cur_n_of(d) + 3 + nstall;
        accept_frame(d, rel);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; stall = 1'b0; start0 = 1'b0; start1 = 1'b0;
  endtask

  function automatic int cur_n_of(input int d);
    return d ? 49 : 25;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram0[i] = (i < 25) ? 8'(i - 12) : 8'sd0;
      ram1[i] = 8'sd7;
    end
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; stall = 1'b0;
    start0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid_pixel", int'(if0.valid_pixel), 0);
    chk("reset pixel_out", int'(if0.pixel_out), 0);
    chk("reset frame_last", int'(if0.frame_last), 0);
    chk("reset busy", int'(busy0), 0);
    chk("reset done", int'(done0), 0);
    chk("reset mem_rd_en", int'(if0.mem_rd_en), 0);
    chk("reset mem_addr", int'(if0.mem_addr), 0);
    chk("reset busy pad1", int'(busy1), 0);
    rst = 1'b0; start0 = 1'b0;
    @(posedge clk); #1;

    // Plain 5x5 frame, RAM[i] = i-12
    clear_seq(); start_m[0] = 1'b1;
    run_seq(0, 32);
    chk("t1 first busy", first_busy, 1);
    chk("t1 first valid", first_v, 3);
    chk("t1 frame_last cycle", last_c, 27);
    chk("t1 done cycle", done_c, 28);
    chk("t1 busy low", busy_low, 29);
    chk("t1 pixel count", nvalid, 25);
    chk("t1 read count", nrd, 25);
    chk("t1 first pixel", int'(first_pix), -12);
    chk("t1 last pixel", int'(last_pix), 12);
    chk("t1 pixels drained", exp_pix.size(), 0);

    // PAD=1 border around an all-7 image
    clear_seq(); start_m[0] = 1'b1;
    run_seq(1, 56);
    chk("t2 first valid", first_v, 3);
    chk("t2 frame_last cycle", last_c, 51);
    chk("t2 done cycle", done_c, 52);
    chk("t2 busy low", busy_low, 53);
    chk("t2 pixel count", nvalid, 49);
    chk("t2 read count", nrd, 25);
    chk("t2 zero pixels", nzero, 24);
    chk("t2 addresses drained", exp_addr.size(), 0);

    // Stall in cycles 4-6 and 10
    clear_seq(); start_m[0] = 1'b1;
    stall_m[4] = 1'b1; stall_m[5] = 1'b1; stall_m[6] = 1'b1; stall_m[10] = 1'b1;
    run_seq(0, 36);
    chk("t3 pixel count", nvalid, 25);
    chk("t3 gaps", gaps, 4);
    chk("t3 frame_last cycle", last_c, 31);
    chk("t3 done cycle", done_c, 32);
    chk("t3 busy low", busy_low, 33);
    chk("t3 last pixel", int'(last_pix), 12);

    // Reset in cycle 10, restart in cycle 15
    clear_seq(); start_m[0] = 1'b1; start_m[15] = 1'b1; rst_at = 10;
    run_seq(0, 48);
    chk("t4 first valid after restart", first_v, 18);
    chk("t4 first pixel after restart", int'(first_pix), -12);
    chk("t4 pixel count after restart", nvalid, 25);
    chk("t4 frame_last cycle", last_c, 42);
    chk("t4 done cycle", done_c, 43);
    chk("t4 busy low", busy_low, 44);

    // start while busy is ignored; start right after done is taken
    clear_seq(); start_m[0] = 1'b1; start_m[5] = 1'b1; start_m[29] = 1'b1;
    run_seq(0, 64);
    chk("t5 total pixels", tot_valid, 50);
    chk("t5 done pulses", tot_done, 2);
    chk("t5 second first valid", first_v, 32);
    chk("t5 second done cycle", done_c, 57);
    chk("t5 second pixel count", nvalid, 25);
    chk("t5 pixels drained", exp_pix.size(), 0);

    monitor_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
